lza_norm_round: RTL and testbench

- Consumer end of the leading-zero anticipator: takes the un-normalized adder magnitude plus the LZA count/invalid flag and produces a normalized, rounded FP result.
- Stage 1 shifts left by the anticipated count. Stage 2 corrects the LZA's possible one-bit under-estimate, adjusts the exponent, rounds (RNE) and handles carry-out, overflow and underflow.
- Sits after the PE adder/LZA pair, before result writeback.
- 2-stage pipeline with valid/ready backpressure.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/norm_shift.sv | 24 ++
 rtl/lza_norm_round.sv | 164 ++++++++++++++++
 tb/tb_lza_norm_round.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, result flags and rounding helper for the
// normalize/round back end of the FP adder.
package fp_pkg;

    localparam int WIDTH = 107;
    localparam int MAN_W = 52;
    localparam int EXP_W = 11;
    localparam int CNT_W = 7;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    typedef struct packed {
        logic zero;
        logic of;
        logic uf;
        logic inexact;
    } res_flags_t;

    function automatic logic rne_up(
        input logic guard,
        input logic sticky,
        input logic lsb
    );
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/norm_shift.sv
// Logarithmic barrel left shifter used for normalization.
// Counts of WIDTH or more are screened off by the caller.
module norm_shift #(
    parameter int WIDTH = 107,
    parameter int CNT_W = 7
) (
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] v;

    always_comb begin
        v = din;
        for (int i = 0; i < CNT_W; i++) begin
            if (cnt[i]) begin
                v = v << (2 ** i);
            end
        end
        dout = v;
    end

endmodule

// File: rtl/lza_norm_round.sv
// Two-stage normalize + RNE round of the adder magnitude using
// the LZA count; stage 2 fixes the LZA's one-bit under-estimate.
module lza_norm_round #(
    parameter int WIDTH = fp_pkg::WIDTH,
    parameter int MAN_W = fp_pkg::MAN_W,
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int CNT_W = fp_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_sum,
    input  logic [CNT_W-1:0]   in_zero_cnt,
    input  logic               in_invalid,
    input  logic               in_sign,
    input  logic [EXP_W+1:0]   in_exp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [EXP_W-1:0]   out_exp,
    output logic [MAN_W-1:0]   out_man,
    output logic               out_zero,
    output logic               out_of,
    output logic               out_uf,
    output logic               out_inexact
);

    import fp_pkg::*;

    localparam int EI_W = EXP_W + 4;
    localparam logic signed [EI_W-1:0] EMAX = EI_W'((1 << EXP_W) - 1);

    logic                    rdy_q;
    logic                    s1_valid;
    logic                    s1_zero;
    logic                    s1_sign;
    logic [WIDTH-1:0]        s1_sh;
    logic signed [EI_W-1:0]  s1_exp;
    logic                    s2_valid;

    logic                    s1_adv;
    logic                    s2_adv;
    logic                    in_fire;

    logic [WIDTH-1:0]        sh_d;
    logic                    zero_d;
    logic signed [EI_W-1:0]  e1_d;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = rdy_q && s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_valid = s2_valid;

    norm_shift #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .din  (in_sum),
        .cnt  (in_zero_cnt),
        .dout (sh_d)
    );

    assign zero_d = in_invalid || (in_zero_cnt >= CNT_W'(WIDTH));
    assign e1_d = $signed({{(EI_W-EXP_W-2){in_exp[EXP_W+1]}}, in_exp})
                - $signed({{(EI_W-CNT_W){1'b0}}, in_zero_cnt});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sh    <= '0;
            s1_exp   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_zero <= zero_d;
                s1_sign <= in_sign;
                s1_sh   <= zero_d ? '0 : sh_d;
                s1_exp  <= e1_d;
            end
        end
    end

    // Stage 2: one-step correction, field extraction, RNE, classify.
    logic                    norm;
    logic [WIDTH-2:0]        sh2;
    logic signed [EI_W-1:0]  e_c;
    logic [MAN_W-1:0]        frac;
    logic                    guard;
    logic                    sticky;
    logic                    up;
    logic                    carry;
    logic [MAN_W-1:0]        frac_r;
    logic signed [EI_W-1:0]  e_r;
    res_flags_t              fl;
    logic [EXP_W-1:0]        exp_d;
    logic [MAN_W-1:0]        man_d;

    assign norm   = s1_zero || s1_sh[WIDTH-1];
    assign sh2    = norm ? s1_sh[WIDTH-2:0] : {s1_sh[WIDTH-3:0], 1'b0};
    assign e_c    = s1_exp - EI_W'(!norm);
    assign frac   = sh2[WIDTH-2 -: MAN_W];
    assign guard  = sh2[WIDTH-2-MAN_W];
    assign sticky = |sh2[WIDTH-3-MAN_W:0];
    assign up     = rne_up(guard, sticky, frac[0]);
    assign {carry, frac_r} = {1'b0, frac} + (MAN_W+1)'(up);
    assign e_r    = e_c + EI_W'(carry);

    always_comb begin
        fl         = '0;
        exp_d      = '0;
        man_d      = '0;
        fl.inexact = guard | sticky;
        if (s1_zero) begin
            fl.zero    = 1'b1;
            fl.inexact = 1'b0;
        end else if (e_r <= 0) begin
            fl.uf   = 1'b1;
            fl.zero = 1'b1;
        end else if (e_r >= EMAX) begin
            fl.of = 1'b1;
            exp_d = '1;
        end else begin
            exp_d = e_r[EXP_W-1:0];
            man_d = frac_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_man     <= '0;
            out_zero    <= 1'b0;
            out_of      <= 1'b0;
            out_uf      <= 1'b0;
            out_inexact <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign    <= s1_sign;
                out_exp     <= exp_d;
                out_man     <= man_d;
                out_zero    <= fl.zero;
                out_of      <= fl.of;
                out_uf      <= fl.uf;
                out_inexact <= fl.inexact;
            end
        end
    end

endmodule

// File: tb/tb_lza_norm_round.sv
// Self-checking bench for lza_norm_round: directed corner cases,
// backpressure, mid-stream reset and a randomized stream.
module tb_lza_norm_round;

    typedef logic [67:0] res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [106:0]  in_sum = '0;
    logic [6:0]    in_zero_cnt = '0;
    logic          in_invalid = 1'b0;
    logic          in_sign = 1'b0;
    logic [12:0]   in_exp = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sign;
    logic [10:0]   out_exp;
    logic [51:0]   out_man;
    logic          out_zero;
    logic          out_of;
    logic          out_uf;
    logic          out_inexact;

    int   total = 0;
    int   bad = 0;
    res_t exp_q[$];
    bit   stall_prev = 1'b0;
    res_t held = '0;

    always #5 clk = ~clk;

    lza_norm_round dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_zero_cnt (in_zero_cnt),
        .in_invalid  (in_invalid),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_exp     (out_exp),
        .out_man     (out_man),
        .out_zero    (out_zero),
        .out_of      (out_of),
        .out_uf      (out_uf),
        .out_inexact (out_inexact)
    );

    function automatic res_t mk(bit s, logic [10:0] e, logic [51:0] m,
                                bit z, bit o, bit u, bit x);
        return {s, e, m, z, o, u, x};
    endfunction

    // Reference: normalize on the true leading one, round the
    // 53-bit significand to nearest-even, then classify.
    function automatic res_t model(logic [106:0] sum, int cnt, bit inv,
                                   bit s, int ex);
        int           p;
        int           e;
        logic [106:0] m;
        logic [53:0]  sig;
        logic [53:0]  rem;
        logic [53:0]  half;
        bit           x;
        if (inv || cnt >= 107) return mk(s, 0, 0, 1, 0, 0, 0);
        p = 0;
        for (int i = 0; i < 107; i++) if (sum[i]) p = i;
        m    = sum << (106 - p);
        e    = ex - (106 - p);
        sig  = {1'b0, m[106:54]};
        rem  = m[53:0];
        half = 54'd1 << 53;
        if (rem > half || (rem == half && sig[0])) sig = sig + 1;
        if (sig[53]) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        x = (rem != 0);
        if (e <= 0) return mk(s, 0, 0, 1, 0, 1, x);
        if (e >= 2047) return mk(s, 11'h7ff, 0, 0, 1, 0, x);
        return mk(s, 11'(e), sig[51:0], 0, 0, 0, x);
    endfunction

    task automatic chk(string tag, res_t got, res_t want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic res_t outs();
        return {out_sign, out_exp, out_man, out_zero, out_of, out_uf,
                out_inexact};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", res_t'(out_valid), res_t'(1));
                chk("stall_hold", outs(), held);
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", res_t'(exp_q.size() != 0), res_t'(1));
                if (exp_q.size() != 0) chk("result", outs(), exp_q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            held = outs();
        end
    end

    task automatic send(logic [106:0] sum, int cnt, bit inv, bit s,
                        int ex, res_t want, bit rnd_rdy);
        bit acc;
        int n;
        in_valid    = 1'b1;
        in_sum      = sum;
        in_zero_cnt = 7'(cnt);
        in_invalid  = inv;
        in_sign     = s;
        in_exp      = 13'(ex);
        acc = 1'b0;
        n = 0;
        do begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        chk("send_accept", res_t'(acc), res_t'(1));
        if (acc) exp_q.push_back(want);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", res_t'(exp_q.size()), res_t'(0));
    endtask

    function automatic logic [106:0] bit_at(int k);
        return 107'd1 << k;
    endfunction

    initial begin
        logic [106:0] s;
        logic [106:0] sa [4];
        int           ca [4];
        int           p;
        int           lz;
        int           cnt;
        int           ex;
        bit           inv;
        bit           sg;

        #1;
        chk("reset_outs", {outs(), out_valid}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", res_t'(in_ready), res_t'(1));

        send(bit_at(106), 0, 0, 0, 1023,
             mk(0, 1023, 0, 0, 0, 0, 0), 0);
        drain();
        send(bit_at(105), 0, 0, 1, 1023,
             mk(1, 1022, 0, 0, 0, 0, 0), 0);
        drain();
        send(bit_at(106) | bit_at(54) | bit_at(53), 0, 0, 0, 1000,
             mk(0, 1000, 52'd2, 0, 0, 0, 1), 0);
        drain();
        send(bit_at(106) | bit_at(53), 0, 0, 0, 1000,
             mk(0, 1000, 52'd0, 0, 0, 0, 1), 0);
        drain();
        s = ~(bit_at(53) - 107'd1);
        send(s, 0, 0, 0, 1000, mk(0, 1001, 0, 0, 0, 0, 1), 0);
        send(s, 0, 0, 1, 2046, mk(1, 11'h7ff, 0, 0, 1, 0, 1), 0);
        drain();
        send(bit_at(106), 0, 1, 1, 1023, mk(1, 0, 0, 1, 0, 0, 0), 0);
        send(bit_at(106), 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 1, 0), 0);
        send(107'd1, 106, 0, 0, 1200, mk(0, 1094, 0, 0, 0, 0, 0), 0);
        send(bit_at(106), 120, 0, 0, 1023, mk(0, 0, 0, 1, 0, 0, 0), 0);
        drain();

        // Backpressure: two beats fill the pipe, then input stalls.
        for (int i = 0; i < 4; i++) begin
            sa[i] = bit_at(106 - i) | 107'($urandom);
            ca[i] = i;
        end
        out_ready = 1'b0;
        send(sa[0], ca[0], 0, 0, 900, model(sa[0], ca[0], 0, 0, 900), 0);
        send(sa[1], ca[1], 0, 1, 901, model(sa[1], ca[1], 0, 1, 901), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("in_ready_full", res_t'(in_ready), res_t'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(sa[2], ca[2], 0, 0, 902, model(sa[2], ca[2], 0, 0, 902), 0);
        send(sa[3], ca[3], 0, 1, 903, model(sa[3], ca[3], 0, 1, 903), 0);
        drain();

        // Reset with beats in flight: nothing may come out afterwards.
        out_ready = 1'b0;
        send(bit_at(106), 0, 0, 0, 500, mk(0, 500, 0, 0, 0, 0, 0), 0);
        send(bit_at(106), 0, 0, 0, 501, mk(0, 501, 0, 0, 0, 0, 0), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", res_t'(out_valid), res_t'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_beat", res_t'(out_valid), res_t'(0));
        end
        @(posedge clk);
        #1;

        for (int k = 0; k < 300; k++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            s = s >> $urandom_range(0, 106);
            if (s == 0) s = 107'd1;
            p = 0;
            for (int i = 0; i < 107; i++) if (s[i]) p = i;
            if ($urandom_range(0, 3) == 0 && p >= 53) begin
                s = s & ~(bit_at(p - 53) - 107'd1);
                s = s | bit_at(p - 53);
            end else if ($urandom_range(0, 7) == 0) begin
                s = (bit_at(p) << 1) - 107'd1;
            end
            lz  = 106 - p;
            cnt = (lz > 0 && $urandom_range(0, 1) == 1) ? lz - 1 : lz;
            if ($urandom_range(0, 31) == 0) cnt = $urandom_range(107, 127);
            inv = ($urandom_range(0, 15) == 0);
            sg  = 1'($urandom_range(0, 1));
            ex  = int'($urandom_range(0, 2300)) - 100;
            send(s, cnt, inv, sg, ex, model(s, cnt, inv, sg, ex), 1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
